// File: rtl/disp_pkg.sv
// Shared types and helpers for the display page scheduler.
package disp_pkg;

  localparam int unsigned PAGE_W  = 2;
  localparam int unsigned MAX_SRC = 4;
  localparam int unsigned DWELL_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    ALARM = 2'd2
  } state_t;

  // First set bit of vld at cur+1, cur+2, ... wrapping, with cur itself last.
  // Zero-padding vld to MAX_SRC makes the mod-4 walk equal to a mod-N_SRC walk.
  function automatic logic [PAGE_W-1:0] next_vld(input logic [MAX_SRC-1:0] vld,
                                                  input logic [PAGE_W-1:0]  cur);
    logic [PAGE_W-1:0] idx;
    next_vld = cur;
    for (int k = MAX_SRC; k >= 1; k--) begin
      idx = cur + PAGE_W'(k);
      if (vld[idx]) next_vld = idx;
    end
  endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Rotate-and-priority search for the next valid source after a given index.
module rr_next_sel
  import disp_pkg::*;
#(
  parameter int unsigned N_SRC = 4
) (
  input  logic [N_SRC-1:0]  i_vld,
  input  logic [PAGE_W-1:0] i_cur,
  output logic [PAGE_W-1:0] o_idx_c,
  output logic              o_found_c
);

  logic [MAX_SRC-1:0] w_vld;

  assign w_vld     = MAX_SRC'(i_vld);
  assign o_idx_c   = next_vld(w_vld, i_cur);
  assign o_found_c = |i_vld;

endmodule

// File: rtl/disp_page_sched.sv
// Page scheduler feeding the 4-digit 7-seg driver: dwell/button rotation, invalid-source skip, alarm preempt.
// Optional DISP_BLINK_EN: decimal point blinks every BLINK_MS ticks while the alarm page is shown.
module disp_page_sched
  import disp_pkg::*;
#(
  parameter int unsigned N_SRC    = 4,
  parameter int unsigned PAGE_MS  = 2000,
  parameter int unsigned BLINK_MS = 250
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce1ms,
  input  logic [N_SRC-1:0]     src_vld,
  input  logic [16*N_SRC-1:0]  src_dat,
  input  logic [N_SRC-1:0]     src_dp,
  input  logic                 alarm,
  input  logic                 btn_next,
  input  logic                 auto_en,
  output logic [15:0]          dat,
  output logic                 set_P,
  output logic [PAGE_W-1:0]    page,
  output logic                 page_vld
);

  if (N_SRC < 2 || N_SRC > MAX_SRC || PAGE_MS < 1 || PAGE_MS > 65535 || BLINK_MS < 1) begin : g_bad_cfg
    $error("disp_page_sched: parameter out of range");
  end

  state_t               r_state;
  logic [PAGE_W-1:0]    r_page;
  logic [PAGE_W-1:0]    r_saved;
  logic [DWELL_W-1:0]   r_dwell;

  logic [15:0]          w_dat [N_SRC];
  logic [PAGE_W-1:0]    w_cur;
  logic [PAGE_W-1:0]    w_nxt_idx;
  logic                 w_nxt_found;
  logic                 w_dwell_exp;
  logic                 w_adv;

  for (genvar i = 0; i < N_SRC; i++) begin : g_dat
    assign w_dat[i] = src_dat[16*i +: 16];
  end

  // Search origin: IDLE looks for the lowest valid, ALARM resumes after the saved page.
  always_comb begin
    w_cur = r_page;
    case (r_state)
      IDLE:    w_cur = PAGE_W'(N_SRC - 1);
      ALARM:   w_cur = r_saved;
      default: w_cur = r_page;
    endcase
  end

  rr_next_sel #(.N_SRC(N_SRC)) u_next (
    .i_vld     (src_vld),
    .i_cur     (w_cur),
    .o_idx_c   (w_nxt_idx),
    .o_found_c (w_nxt_found)
  );

  assign w_dwell_exp = ce1ms && auto_en && (r_dwell == DWELL_W'(PAGE_MS - 1));
  assign w_adv       = btn_next || w_dwell_exp || !src_vld[r_page];
  assign page        = r_page;

`ifdef DISP_BLINK_EN
  logic               r_blink;
  logic [15:0]        r_blink_cnt;

  // Blink phase restarts at 1 on every alarm entry and only runs while in ALARM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_blink     <= 1'b0;
      r_blink_cnt <= '0;
    end else if (r_state != ALARM && alarm) begin
      r_blink     <= 1'b1;
      r_blink_cnt <= '0;
    end else if (r_state == ALARM && ce1ms) begin
      if (r_blink_cnt == 16'(BLINK_MS - 1)) begin
        r_blink     <= ~r_blink;
        r_blink_cnt <= '0;
      end else begin
        r_blink_cnt <= r_blink_cnt + 16'd1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_page   <= '0;
      r_saved  <= '0;
      r_dwell  <= '0;
      dat      <= '0;
      set_P    <= 1'b0;
      page_vld <= 1'b0;
    end else begin
      // Display word lags the page register by one cycle.
      if (r_state == IDLE) begin
        dat      <= '0;
        set_P    <= 1'b0;
        page_vld <= 1'b0;
      end else begin
        dat      <= w_dat[r_page];
        page_vld <= src_vld[r_page];
`ifdef DISP_BLINK_EN
        set_P    <= (r_state == ALARM) ? r_blink : src_dp[r_page];
`else
        set_P    <= src_dp[r_page];
`endif
      end

      case (r_state)
        IDLE: begin
          if (alarm) begin
            r_state <= ALARM;
            r_saved <= r_page;
            r_page  <= '0;
          end else if (w_nxt_found) begin
            r_state <= SHOW;
            r_page  <= w_nxt_idx;
            r_dwell <= '0;
          end
        end
        SHOW: begin
          if (alarm) begin
            r_state <= ALARM;
            r_saved <= r_page;
            r_page  <= '0;
          end else if (!w_nxt_found) begin
            r_state <= IDLE;
          end else if (w_adv) begin
            // All triggers in one cycle collapse into one step.
            r_page  <= w_nxt_idx;
            r_dwell <= '0;
          end else if (ce1ms && auto_en) begin
            r_dwell <= r_dwell + DWELL_W'(1);
          end
        end
        ALARM: begin
          if (!alarm) begin
            r_state <= w_nxt_found ? SHOW : IDLE;
            r_page  <= src_vld[r_saved] ? r_saved : w_nxt_idx;
            r_dwell <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_disp_page_sched.sv
// Directed scoreboard bench for disp_page_sched (PAGE_MS=3, BLINK_MS=2).
module tb_disp_page_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce1ms;
  logic [3:0]  src_vld;
  logic [63:0] src_dat;
  logic [3:0]  src_dp;
  logic        alarm;
  logic        btn_next;
  logic        auto_en;
  logic [15:0] dat;
  logic        set_P;
  logic [1:0]  page;
  logic        page_vld;

  always #5 clk = ~clk;

  logic [15:0] tbl [4] = '{16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3};
  logic [3:0]  dp_c    = 4'b1010;

  assign src_dat = {tbl[3], tbl[2], tbl[1], tbl[0]};
  assign src_dp  = dp_c;

  disp_page_sched #(.N_SRC(4), .PAGE_MS(3), .BLINK_MS(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce1ms    (ce1ms),
    .src_vld  (src_vld),
    .src_dat  (src_dat),
    .src_dp   (src_dp),
    .alarm    (alarm),
    .btn_next (btn_next),
    .auto_en  (auto_en),
    .dat      (dat),
    .set_P    (set_P),
    .page     (page),
    .page_vld (page_vld)
  );

  typedef struct {
    logic [1:0]  page;
    logic [15:0] dat;
    logic        p;
    logic        pv;
    bit          chk_p;
    int          id;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   step_no = 0;
  int   p_ovr = -1;   // -1: expect src_dp of the shown source, 0/1: forced, 2: not checked

  function automatic void chk(input string nm, input int id, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s step %0d: got %h want %h", nm, id, act, req);
    end
  endfunction

  // Drive one cycle and queue the outputs expected just after the next rising edge.
  task automatic step(input logic ce, input logic btn, input int ep, input int dsrc, input logic epv);
    exp_t e;
    ce1ms    = ce;
    btn_next = btn;
    e.page   = 2'(ep);
    e.id     = step_no;
    e.chk_p  = 1'b1;
    if (dsrc < 0) begin
      e.dat = 16'h0000;
      e.p   = 1'b0;
      e.pv  = 1'b0;
    end else begin
      e.dat = tbl[dsrc];
      e.p   = dp_c[dsrc];
      e.pv  = epv;
    end
    if (p_ovr == 2) e.chk_p = 1'b0;
    else if (p_ovr >= 0) e.p = (p_ovr != 0);
    q.push_back(e);
    step_no++;
    @(negedge clk);
  endtask

  exp_t m;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        m = q.pop_front();
        chk("page",     m.id, 16'(page),     16'(m.page));
        chk("dat",      m.id, dat,           m.dat);
        chk("page_vld", m.id, 16'(page_vld), 16'(m.pv));
        if (m.chk_p) chk("set_P", m.id, 16'(set_P), 16'(m.p));
      end
    end
  end

  initial begin
    rst_n = 1'b0; ce1ms = 1'b0; btn_next = 1'b0; alarm = 1'b0; auto_en = 1'b1; src_vld = 4'b1111;
    step(0, 0, 0, -1, 0);
    step(1, 0, 0, -1, 0);
    rst_n = 1'b1;

    // auto rotation every 3 ticks, wrap 3 -> 0
    step(0, 0, 0, -1, 0);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(1, 0, 1, 0, 1);
    for (int pg = 1; pg < 4; pg++) begin
      step(1, 0, pg, pg, 1);
      step(1, 0, pg, pg, 1);
      step(1, 0, (pg + 1) % 4, pg, 1);
    end

    // manual stepping over sparse sources; dwell frozen while auto is off
    src_vld = 4'b0101; auto_en = 1'b0;
    step(0, 1, 2, 0, 1);
    step(0, 1, 0, 2, 1);
    repeat (4) step(1, 0, 0, 0, 1);
    auto_en = 1'b1;
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 2, 0, 1);
    src_vld = 4'b0001;
    step(0, 0, 0, 2, 0);
    step(1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    src_vld = 4'b0101;
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 2, 0, 1);

    // current source drops, then all drop -> IDLE
    src_vld = 4'b1111; step(0, 0, 2, 2, 1);
    src_vld = 4'b1011; step(0, 0, 3, 2, 0);
    src_vld = 4'b0000; step(0, 0, 3, 3, 0);
    step(1, 0, 3, -1, 0);
    src_vld = 4'b1000; step(0, 0, 3, -1, 0);
    src_vld = 4'b1111; step(1, 0, 3, 3, 1);

    // alarm preempt from page 3, buttons ignored, return to saved page with dwell cleared
    alarm = 1'b1;
    step(0, 0, 0, 3, 1);
    for (int k = 0; k < 10; k++) begin
      src_vld = (k == 4) ? 4'b1110 : 4'b1111;
`ifdef DISP_BLINK_EN
      p_ovr = ((k / 2) % 2 == 0) ? 1 : 0;
`else
      p_ovr = -1;
`endif
      step(1, (k % 2 == 1), 0, 0, (k != 4));
    end
    alarm = 1'b0;
`ifdef DISP_BLINK_EN
    p_ovr = 0;
`endif
    step(0, 0, 3, 0, 1);
    p_ovr = -1;
    step(1, 0, 3, 3, 1);
    step(1, 0, 3, 3, 1);
    step(1, 0, 0, 3, 1);

    // button coincident with dwell expiry gives one advance
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 1, 0, 1);
    step(1, 0, 1, 1, 1);
    step(1, 0, 1, 1, 1);
    step(1, 1, 2, 1, 1);
    step(1, 0, 2, 2, 1);

    // reset in the middle of an alarm
    alarm = 1'b1;
    step(0, 0, 0, 2, 1);
`ifdef DISP_BLINK_EN
    p_ovr = 1;
`endif
    step(1, 0, 0, 0, 1);
    p_ovr = -1;
    rst_n = 1'b0;
    step(1, 0, 0, -1, 0);
    rst_n = 1'b1; alarm = 1'b0;
    step(0, 0, 0, -1, 0);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 1, 0, 1);

    ce1ms = 1'b0; btn_next = 1'b0;
    repeat (3) @(negedge clk);
    chk("drain", step_no, 16'(q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
